life_engine: RTL and testbench

Game-of-Life state engine for the 10x10 display grid. It holds the current cell map and computes the next generation row by row on request. It applies cursor edits (toggle, clear) between generations and presents the map as a flat vector to the VGA pattern generator downstream. That generator reads bit `x + y*GRID_W` as cell (x,y).

---
 rtl/life_pkg.sv | 24 ++
 rtl/life_row_next.sv | 37 +++
 rtl/life_engine.sv | 142 ++++++++++++++
 tb/tb_life_engine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life engine: grid defaults, FSM states,
// B3/S23 rule constants and the flat cell-index helper.
package life_pkg;

   localparam int unsigned DEF_GRID_W = 10;
   localparam int unsigned DEF_GRID_H = 10;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      COMMIT
   } state_e;

   localparam logic [3:0] BIRTH_CNT  = 4'd3;
   localparam logic [3:0] SURVIVE_LO = 4'd2;
   localparam logic [3:0] SURVIVE_HI = 4'd3;

   function automatic int unsigned cell_idx(input int unsigned x,
                                            input int unsigned y,
                                            input int unsigned w);
      return x + y * w;
   endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-state for one grid row from the rows above, at and below it.
module life_row_next
   import life_pkg::*;
#(
   parameter int unsigned GRID_W = DEF_GRID_W
) (
   input  logic              wrap,
   input  logic [GRID_W-1:0] row_above,
   input  logic [GRID_W-1:0] row_cur,
   input  logic [GRID_W-1:0] row_below,
   output logic [GRID_W-1:0] row_next
);

   // Each row padded with one column per side: bit c+1 is column c,
   // pads hold the opposite edge column when wrapping, else dead.
   logic [GRID_W+1:0] ext_a;
   logic [GRID_W+1:0] ext_c;
   logic [GRID_W+1:0] ext_b;

   always_comb begin
      ext_a = {wrap & row_above[0], row_above, wrap & row_above[GRID_W-1]};
      ext_c = {wrap & row_cur[0],   row_cur,   wrap & row_cur[GRID_W-1]};
      ext_b = {wrap & row_below[0], row_below, wrap & row_below[GRID_W-1]};
   end

   for (genvar c = 0; c < GRID_W; c++) begin : g_cell
      logic [3:0] cnt;

      assign cnt = 4'(ext_a[c]) + 4'(ext_a[c+1]) + 4'(ext_a[c+2])
                 + 4'(ext_c[c])                  + 4'(ext_c[c+2])
                 + 4'(ext_b[c]) + 4'(ext_b[c+1]) + 4'(ext_b[c+2]);

      assign row_next[c] = (cnt == BIRTH_CNT)
                        || (row_cur[c] && ((cnt == SURVIVE_LO) || (cnt == SURVIVE_HI)));
   end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life state engine: holds the cell map, applies cursor edits in IDLE
// and computes the next generation one row per cycle into a shadow map.
module life_engine
   import life_pkg::*;
#(
   parameter int unsigned                  GRID_W   = DEF_GRID_W,
   parameter int unsigned                  GRID_H   = DEF_GRID_H,
   parameter logic [GRID_W*GRID_H-1:0]     INIT_MAP = '0,
   parameter bit                           WRAP     = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     step,
   input  logic                     toggle,
   input  logic                     clear,
   input  logic [3:0]               cur_x,
   input  logic [3:0]               cur_y,
   output logic [GRID_W*GRID_H-1:0] grid_map,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              generation
);

   localparam int unsigned   N        = GRID_W * GRID_H;
   localparam int unsigned   RW       = (GRID_H > 1) ? $clog2(GRID_H) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(GRID_H - 1);

   state_e              state_q, state_d;
   logic [N-1:0]        map_q, map_d;
   logic [GRID_W-1:0]   next_q [GRID_H];
   logic [GRID_W-1:0]   next_d [GRID_H];
   logic [15:0]         gen_q, gen_d;
   logic [RW-1:0]       row_q, row_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [GRID_W-1:0]   map_rows [GRID_H];
   logic [N-1:0]        next_flat;
   logic [N-1:0]        tog_mask;
   logic [GRID_W-1:0]   row_up, row_mid, row_dn, row_new;

   // Out-of-range cursors simply match no mask bit, so the toggle is a no-op.
   for (genvar r = 0; r < GRID_H; r++) begin : g_row
      assign map_rows[r]                    = map_q[r*GRID_W +: GRID_W];
      assign next_flat[r*GRID_W +: GRID_W]  = next_q[r];
      for (genvar c = 0; c < GRID_W; c++) begin : g_col
         assign tog_mask[cell_idx(c, r, GRID_W)] = (cur_x == 4'(c)) && (cur_y == 4'(r));
      end
   end

   always_comb begin
      row_up  = '0;
      row_dn  = '0;
      row_mid = map_rows[row_q];
      if (row_q == '0) begin
         if (WRAP) row_up = map_rows[LAST_ROW];
      end else begin
         row_up = map_rows[row_q - 1'b1];
      end
      if (row_q == LAST_ROW) begin
         if (WRAP) row_dn = map_rows[0];
      end else begin
         row_dn = map_rows[row_q + 1'b1];
      end
   end

   life_row_next #(
      .GRID_W (GRID_W)
   ) u_row_next (
      .wrap      (WRAP),
      .row_above (row_up),
      .row_cur   (row_mid),
      .row_below (row_dn),
      .row_next  (row_new)
   );

   always_comb begin
      state_d = state_q;
      map_d   = map_q;
      next_d  = next_q;
      gen_d   = gen_q;
      row_d   = row_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (clear) begin
               map_d = '0;
               gen_d = '0;
            end else if (step) begin
               row_d   = '0;
               busy_d  = 1'b1;
               state_d = COMPUTE;
            end else if (toggle) begin
               map_d = map_q ^ tog_mask;
            end
         end
         COMPUTE: begin
            next_d[row_q] = row_new;
            if (row_q == LAST_ROW) begin
               state_d = COMMIT;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         COMMIT: begin
            map_d   = next_flat;
            gen_d   = gen_q + 16'd1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         map_q   <= INIT_MAP;
         next_q  <= '{default: '0};
         gen_q   <= '0;
         row_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         map_q   <= map_d;
         next_q  <= next_d;
         gen_q   <= gen_d;
         row_q   <= row_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign grid_map   = map_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign generation = gen_q;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: edit vector table plus generation sequences
// on a bounded and a toroidal instance driven with identical stimulus.
module tb_life_engine;

   localparam int W = 10;
   localparam int H = 10;
   localparam int N = W * H;
   localparam logic [N-1:0] INIT = (100'b1 << 34) | (100'b1 << 44) | (100'b1 << 54);

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         step = 1'b0;
   logic         toggle = 1'b0;
   logic         clear = 1'b0;
   logic [3:0]   cur_x = 4'd0;
   logic [3:0]   cur_y = 4'd0;
   logic [N-1:0] map0, map1;
   logic         busy0, busy1, done0, done1;
   logic [15:0]  gen0, gen1;

   int n_cmp = 0;
   int n_bad = 0;

   life_engine #(.GRID_W(W), .GRID_H(H), .INIT_MAP(INIT), .WRAP(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .step(step), .toggle(toggle), .clear(clear),
      .cur_x(cur_x), .cur_y(cur_y), .grid_map(map0), .busy(busy0), .done(done0),
      .generation(gen0)
   );

   life_engine #(.GRID_W(W), .GRID_H(H), .INIT_MAP(INIT), .WRAP(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n), .step(step), .toggle(toggle), .clear(clear),
      .cur_x(cur_x), .cur_y(cur_y), .grid_map(map1), .busy(busy1), .done(done1),
      .generation(gen1)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          clr;
      bit          stp;
      bit          tog;
      logic [3:0]  x;
      logic [3:0]  y;
      int          b0, b1, b2, b3;
      logic [15:0] gen;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] mk(input int b0, input int b1, input int b2, input int b3);
      logic [N-1:0] m;
      m = '0;
      if (b0 >= 0) m[b0] = 1'b1;
      if (b1 >= 0) m[b1] = 1'b1;
      if (b2 >= 0) m[b2] = 1'b1;
      if (b3 >= 0) m[b3] = 1'b1;
      return m;
   endfunction

   function automatic logic [N-1:0] life_ref(input logic [N-1:0] m, input bit wrap);
      logic [N-1:0] nm;
      int cnt, nx, ny;
      nm = '0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            cnt = 0;
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  if (dx == 0 && dy == 0) continue;
                  nx = x + dx;
                  ny = y + dy;
                  if (wrap) begin
                     nx = (nx + W) % W;
                     ny = (ny + H) % H;
                  end else if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
                     continue;
                  end
                  if (m[nx + ny*W]) cnt++;
               end
            end
            nm[x + y*W] = (cnt == 3) || (m[x + y*W] && cnt == 2);
         end
      end
      return nm;
   endfunction

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
         chk("busy_done_excl", N'(busy0 & done0), '0);
      end while (!done0 && lat < 40);
   endtask

   task automatic run_gen(output int lat);
      step = 1'b1;
      tick();
      step = 1'b0;
      wait_done(lat);
   endtask

   task automatic toggle_at(input int x, input int y);
      cur_x  = 4'(x);
      cur_y  = 4'(y);
      toggle = 1'b1;
      tick();
      toggle = 1'b0;
   endtask

   initial begin
      int lat;
      int seen;
      logic [N-1:0] block, glider, ref0, ref1;

      // edit vectors, starting from the blinker map after two generations
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  0,  34, 44, 54, 16'd2};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 4'd0,  4'd0,  -1, -1, -1, -1, 16'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'd3,  4'd4,  43, -1, -1, -1, 16'd0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'd12, 4'd0,  43, -1, -1, -1, 16'd0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd12, 43, -1, -1, -1, 16'd0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'd9,  4'd9,  43, 99, -1, -1, 16'd0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'd3,  4'd4,  99, -1, -1, -1, 16'd0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 99, -1, -1, -1, 16'd0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'd9,  4'd0,  9,  99, -1, -1, 16'd0};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd9,  9,  90, 99, -1, 16'd0};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 4'd5,  4'd5,  -1, -1, -1, -1, 16'd0};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 4'd10, 4'd9,  -1, -1, -1, -1, 16'd0};

      // reset state
      #1 reset_n = 1'b0;
      #2;
      chk("rst_map0", map0, INIT);
      chk("rst_map1", map1, INIT);
      chk("rst_gen", N'(gen0), '0);
      chk("rst_busy", N'(busy0), '0);
      chk("rst_done", N'(done0), '0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // blinker: latency, single-cycle done, period 2
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("busy_after_e0", N'(busy0), N'(1));
      wait_done(lat);
      chk("blink_latency", N'(lat), N'(11));
      chk("blink_busy_at_done", N'(busy0), '0);
      chk("blink1_map0", map0, mk(43, 44, 45, -1));
      chk("blink1_map1", map1, mk(43, 44, 45, -1));
      chk("blink1_gen", N'(gen0), N'(1));
      tick();
      chk("done_one_cycle", N'(done0), '0);
      run_gen(lat);
      chk("blink2_map0", map0, INIT);
      chk("blink2_gen", N'(gen0), N'(2));

      // edit table: toggle/clear/priority/range
      for (int i = 0; i < 12; i++) begin
         clear  = tbl[i].clr;
         step   = tbl[i].stp;
         toggle = tbl[i].tog;
         cur_x  = tbl[i].x;
         cur_y  = tbl[i].y;
         tick();
         clear  = 1'b0;
         step   = 1'b0;
         toggle = 1'b0;
         chk($sformatf("vec%0d_map0", i), map0, mk(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3));
         chk($sformatf("vec%0d_map1", i), map1, mk(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3));
         chk($sformatf("vec%0d_gen", i), N'(gen0), N'(tbl[i].gen));
         chk($sformatf("vec%0d_busy", i), N'(busy0), '0);
         chk($sformatf("vec%0d_done", i), N'(done0), '0);
      end

      // block still-life over five generations
      block = mk(11, 12, 21, 22);
      toggle_at(1, 1);
      toggle_at(2, 1);
      toggle_at(1, 2);
      toggle_at(2, 2);
      chk("block_load", map0, block);
      for (int g = 1; g <= 5; g++) begin
         run_gen(lat);
         chk($sformatf("block_lat%0d", g), N'(lat), N'(11));
      end
      chk("block_map0", map0, block);
      chk("block_map1", map1, block);
      chk("block_gen", N'(gen0), N'(5));

      // toggle and clear while busy are dropped
      step = 1'b1;
      tick();
      step   = 1'b0;
      cur_x  = 4'd0;
      cur_y  = 4'd0;
      toggle = 1'b1;
      clear  = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
         if (lat == 8) begin
            toggle = 1'b0;
            clear  = 1'b0;
         end
      end while (!done0 && lat < 40);
      toggle = 1'b0;
      clear  = 1'b0;
      chk("ign_latency", N'(lat), N'(11));
      chk("ign_map", map0, block);
      chk("ign_gen", N'(gen0), N'(6));

      // step held high: back-to-back generations
      step = 1'b1;
      tick();
      wait_done(lat);
      chk("b2b_first", N'(lat), N'(11));
      wait_done(lat);
      step = 1'b0;
      chk("b2b_period", N'(lat), N'(12));
      chk("b2b_gen", N'(gen0), N'(8));
      tick();
      chk("b2b_stopped", N'(busy0), '0);

      // reset asserted at E5 of a step aborts without done
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (4) tick();
      @(posedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort_map0", map0, INIT);
      chk("abort_map1", map1, INIT);
      chk("abort_busy", N'(busy0), '0);
      chk("abort_gen", N'(gen0), '0);
      tick();
      reset_n = 1'b1;
      seen = 0;
      repeat (15) begin
         tick();
         if (done0 || done1) seen++;
      end
      chk("abort_no_done", N'(seen), '0);
      chk("abort_map_hold", map0, INIT);

      // glider toward bottom-right, bounded and toroidal
      clear = 1'b1;
      tick();
      clear = 1'b0;
      toggle_at(6, 5);
      toggle_at(7, 6);
      toggle_at(5, 7);
      toggle_at(6, 7);
      toggle_at(7, 7);
      glider = (100'b1 << 56) | (100'b1 << 67) | (100'b1 << 75) | (100'b1 << 76) | (100'b1 << 77);
      chk("glider_load", map0, glider);
      ref0 = glider;
      ref1 = glider;
      for (int g = 1; g <= 40; g++) begin
         ref0 = life_ref(ref0, 1'b0);
         ref1 = life_ref(ref1, 1'b1);
         run_gen(lat);
         chk($sformatf("glider_nowrap_g%0d", g), map0, ref0);
         chk($sformatf("glider_wrap_g%0d", g), map1, ref1);
      end
      chk("glider_wrap_home", map1, glider);
      chk("glider_corner_block", map0, mk(88, 89, 98, 99));
      chk("glider_gen", N'(gen1), N'(40));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
